sdram_slave_responder: RTL and testbench
========================================

SDRAM_SLAVE_RESPONDER -- requirements
Module: sdram_slave_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDR_BITS, 10, log2 of on-chip word count.
- READ_LATENCY, 2, acceptance-to-readdatavalid cycles (legal 1..8).
- WAIT_PERIOD, 4, accepted transfers between forced one-cycle stalls (0 = never stall).

REQ-002 SHALL have ports (name, direction, width, meaning):
- i_clk, in, 1, sole clock.
- i_rst, in, 1, reset, synchronous, active-high.
- s1_address, in, 23, word address.
- s1_byteenable_n, in, 4, active-low byte lane enables.
- s1_chipselect, in, 1, transfer request qualifier.
- s1_writedata, in, 32, write data.
- s1_read_n, in, 1, active-low read request.
- s1_write_n, in, 1, active-low write request.
- s1_readdata, out, 32, read data.
- s1_readdatavalid, out, 1, readdata valid strobe.
- s1_waitrequest, out, 1, slave stall.
- o_read_count, out, 16, accepted reads, wraps.
- o_write_count, out, 16, accepted writes, wraps.
- o_error, out, 1, sticky protocol error.

REQ-003 SHALL be the Avalon-MM slave end of the SDRAM controller s1 interface driven by the team's SDRAM bus initiator, and SHALL be port-compatible with it.

Function
REQ-004 Accept condition SHALL be: chipselect=1, exactly one of read_n/write_n low, and waitrequest=0 in that cycle.
REQ-005 chipselect=1 with read_n=0 and write_n=0 SHALL NOT be accepted, SHALL set o_error (sticky until reset), and SHALL leave memory and pipeline unchanged.
REQ-006 Storage SHALL be 2^ADDR_BITS x 32 on-chip words, indexed by s1_address[ADDR_BITS-1:0]; upper address bits SHALL be ignored (aliasing).
REQ-007 An accepted write SHALL update only lanes whose byteenable_n bit is 0 (bit0 = [7:0] ... bit3 = [31:24]); byteenable_n=4'hF SHALL count as a write but change nothing.
REQ-008 An accepted read SHALL sample memory at the acceptance edge. Data written by a write accepted in an earlier cycle SHALL be visible; later writes SHALL NOT alter in-flight read data.
REQ-009 For a read accepted at edge N, s1_readdatavalid SHALL be 1 for exactly one cycle, starting after edge N+READ_LATENCY-1 (READ_LATENCY=1: the cycle after acceptance). The pipeline SHALL be a READ_LATENCY-stage valid/data shift register, responses in order, back-to-back reads yielding back-to-back valids.
REQ-010 s1_readdata SHALL hold the last returned value when readdatavalid=0.
REQ-011 The stall FSM SHALL be registered, with states RUN and STALL and a transfer counter (width ceil(log2(WAIT_PERIOD+1))):
- RUN: waitrequest=0; each acceptance increments the counter.
- An acceptance with counter = WAIT_PERIOD-1 SHALL clear the counter and enter STALL.
- STALL: waitrequest=1 for one cycle, then return to RUN.
- WAIT_PERIOD=0: always RUN.
REQ-012 A request presented during STALL SHALL NOT be accepted; the initiator holds it and it SHALL be accepted in the following RUN cycle.
REQ-013 o_read_count/o_write_count SHALL increment by 1 per accepted read/write and wrap FFFF->0000.
REQ-014 A request with chipselect=0 SHALL be ignored regardless of read_n/write_n.

Reset
REQ-015 While i_rst=1 at an edge:
- s1_waitrequest SHALL be 1 (driven combinationally from i_rst).
- Pipeline valids SHALL be flushed and s1_readdatavalid, s1_readdata, counters and o_error SHALL be set to 0.
- The FSM SHALL go to RUN with counter 0.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 Reset asserted with reads in flight SHALL discard them; no readdatavalid SHALL appear for them after reset.

Verification
REQ-018 Write 0x12345678 to addr 5 (be_n=0), then read addr 5 -> readdatavalid exactly READ_LATENCY cycles after acceptance with readdata=0x12345678; write_count=1, read_count=1.
REQ-019 Write 0xFFFFFFFF to addr 7, then 0x00000000 with be_n=4'b1010, read addr 7 -> 0xFF00FF00.
REQ-020 WAIT_PERIOD=4, 6 back-to-back reads of addrs 0..5 -> waitrequest=1 in the cycle after the 4th acceptance only; 6 valids in address order; no read lost or duplicated.
REQ-021 Read addr 3 accepted, write 0xAAAA5555 to addr 3 next cycle -> returned data is the old value; a subsequent read returns 0xAAAA5555.
REQ-022 chipselect=1, read_n=0, write_n=0 -> o_error=1, no counter change, no readdatavalid; o_error stays 1 until reset.
REQ-023 Two reads in flight, i_rst pulsed one cycle -> no readdatavalid thereafter; counters 0; a read of an address written before reset returns the pre-reset data.

Source files
------------

// File: rtl/sdram_slave_responder.sv
// Avalon-MM slave model for the SDRAM controller s1 port: on-chip word store,
// fixed-latency pipelined reads and a periodic one-cycle waitrequest stall.
module sdram_slave_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_PERIOD  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [22:0] s1_address,
    input  logic [3:0]  s1_byteenable_n,
    input  logic        s1_chipselect,
    input  logic [31:0] s1_writedata,
    input  logic        s1_read_n,
    input  logic        s1_write_n,
    output logic [31:0] s1_readdata,
    output logic        s1_readdatavalid,
    output logic        s1_waitrequest,
    output logic [15:0] o_read_count,
    output logic [15:0] o_write_count,
    output logic        o_error
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (WAIT_PERIOD > 0) ? $clog2(WAIT_PERIOD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_PERIOD > 0) ? CNT_W'(WAIT_PERIOD - 1) : '0;

    typedef enum logic {RUN, STALL} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       mem [DEPTH];
    logic              pipe_valid_reg [READ_LATENCY];
    logic [31:0]       pipe_data_reg  [READ_LATENCY];
    logic [15:0]       read_count_reg, write_count_reg;
    logic              error_reg;

    logic [ADDR_BITS-1:0] idx;
    logic req_read, req_write, req_conflict;
    logic accept_read, accept_write, accept;
    logic [3:0] lane_we;

    assign idx          = s1_address[ADDR_BITS-1:0];
    assign req_read     = s1_chipselect && !s1_read_n && s1_write_n;
    assign req_write    = s1_chipselect && s1_read_n && !s1_write_n;
    assign req_conflict = s1_chipselect && !s1_read_n && !s1_write_n;
    assign accept_read  = req_read && !s1_waitrequest;
    assign accept_write = req_write && !s1_waitrequest;
    assign accept       = accept_read || accept_write;

    assign s1_waitrequest   = i_rst || (state_reg == STALL);
    assign s1_readdatavalid = pipe_valid_reg[READ_LATENCY-1];
    assign s1_readdata      = pipe_data_reg[READ_LATENCY-1];
    assign o_read_count     = read_count_reg;
    assign o_write_count    = write_count_reg;
    assign o_error          = error_reg;

    // Upper address bits alias onto the same words.
    generate
        if (ADDR_BITS < 23) begin : g_alias
            logic unused_upper;
            assign unused_upper = ^s1_address[22:ADDR_BITS];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = accept_write && !s1_byteenable_n[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[idx][8*b +: 8] <= s1_writedata[8*b +: 8];
            end
        end
    end

    // Read data is captured at acceptance; the last stage only loads on a
    // valid, so it holds the most recent response between strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_valid_reg[k] <= 1'b0;
                pipe_data_reg[k]  <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= accept_read;
            if (accept_read) begin
                pipe_data_reg[0] <= mem[idx];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                if (pipe_valid_reg[k-1]) begin
                    pipe_data_reg[k] <= pipe_data_reg[k-1];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (accept && (WAIT_PERIOD != 0)) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = STALL;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            STALL:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            read_count_reg  <= '0;
            write_count_reg <= '0;
            error_reg       <= 1'b0;
        end else begin
            if (accept_read) begin
                read_count_reg <= read_count_reg + 16'd1;
            end
            if (accept_write) begin
                write_count_reg <= write_count_reg + 16'd1;
            end
            if (req_conflict) begin
                error_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_slave_responder.sv
// Scoreboard bench for sdram_slave_responder: directed scenarios plus random
// traffic, checked against a word-array / queue reference model.
module tb_sdram_slave_responder;
    localparam int ADDR_BITS = 10;
    localparam int L         = 2;
    localparam int WP        = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [22:0] s1_address = '0;
    logic [3:0]  s1_byteenable_n = 4'hF;
    logic        s1_chipselect = 1'b0;
    logic [31:0] s1_writedata = '0;
    logic        s1_read_n = 1'b1;
    logic        s1_write_n = 1'b1;
    logic [31:0] s1_readdata;
    logic        s1_readdatavalid;
    logic        s1_waitrequest;
    logic [15:0] o_read_count;
    logic [15:0] o_write_count;
    logic        o_error;

    sdram_slave_responder #(
        .ADDR_BITS(ADDR_BITS), .READ_LATENCY(L), .WAIT_PERIOD(WP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s1_address(s1_address), .s1_byteenable_n(s1_byteenable_n),
        .s1_chipselect(s1_chipselect), .s1_writedata(s1_writedata),
        .s1_read_n(s1_read_n), .s1_write_n(s1_write_n),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s1_waitrequest(s1_waitrequest),
        .o_read_count(o_read_count), .o_write_count(o_write_count),
        .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [1 << ADDR_BITS];
    logic [15:0] rd_cnt_m = '0;
    logic [15:0] wr_cnt_m = '0;
    logic        err_m = 1'b0;
    logic [31:0] last_ret = '0;
    int          acc_total = 0;
    int          stall_cyc = -1;
    int          checks = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every cycle compare outputs against the model; pop on valid.
    always @(negedge i_clk) begin
        exp_t e;
        check("waitrequest", 32'(s1_waitrequest), 32'(i_rst || (cyc == stall_cyc)));
        check("read_count", 32'(o_read_count), 32'(rd_cnt_m));
        check("write_count", 32'(o_write_count), 32'(wr_cnt_m));
        check("error", 32'(o_error), 32'(err_m));
        if (s1_readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: got readdatavalid=1 data %h, expected no response (cycle %0d)",
                         s1_readdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("readdata", s1_readdata, e.data);
                check("valid_cycle", 32'(cyc), 32'(e.due));
                last_ret = e.data;
            end
        end else begin
            check("readdatavalid", 32'(s1_readdatavalid), 32'd0);
            check("readdata_hold", s1_readdata, last_ret);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_idle();
        s1_chipselect   = 1'b0;
        s1_read_n       = 1'b1;
        s1_write_n      = 1'b1;
        s1_byteenable_n = 4'hF;
    endtask

    task automatic do_xfer(input bit is_write, input logic [22:0] addr,
                           input logic [31:0] data, input logic [3:0] be_n);
        bit   accepted = 1'b0;
        logic w;
        int   idx = int'(addr[ADDR_BITS-1:0]);
        s1_chipselect   = 1'b1;
        s1_read_n       = is_write;
        s1_write_n      = !is_write;
        s1_address      = addr;
        s1_writedata    = data;
        s1_byteenable_n = be_n;
        for (int t = 0; t < 16 && !accepted; t++) begin
            @(negedge i_clk);
            w = s1_waitrequest;
            tick();
            accepted = (w == 1'b0);
        end
        bus_idle();
        if (!accepted) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got no acceptance, expected one within 16 cycles (addr %h)", addr);
            return;
        end
        if (is_write) begin
            for (int b = 0; b < 4; b++)
                if (!be_n[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
            wr_cnt_m++;
        end else begin
            exp_q.push_back(exp_t'{mem_m[idx], cyc + L - 1});
            rd_cnt_m++;
        end
        acc_total++;
        if (WP != 0 && (acc_total % WP) == 0) stall_cyc = cyc;
    endtask

    task automatic do_bad(input logic [22:0] addr);
        s1_chipselect = 1'b1;
        s1_read_n     = 1'b0;
        s1_write_n    = 1'b0;
        s1_address    = addr;
        tick();
        err_m = 1'b1;
        bus_idle();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_q.delete();
        rd_cnt_m  = '0;
        wr_cnt_m  = '0;
        err_m     = 1'b0;
        last_ret  = '0;
        acc_total = 0;
        stall_cyc = -1;
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && exp_q.size() != 0; t++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op;
        logic [22:0] a;
        repeat (3) tick();
        i_rst = 1'b0;

        // Basic write then read with latency check.
        do_xfer(1'b1, 23'd5, 32'h12345678, 4'h0);
        do_xfer(1'b0, 23'd5, '0, 4'h0);
        drain();
        check("req018_rd_cnt", 32'(o_read_count), 32'd1);
        check("req018_wr_cnt", 32'(o_write_count), 32'd1);

        for (int i = 0; i < 16; i++)
            if (i != 5) do_xfer(1'b1, 23'(i), $urandom, 4'h0);

        // Byte lanes, including an all-disabled write.
        do_xfer(1'b1, 23'd7, 32'hFFFFFFFF, 4'h0);
        do_xfer(1'b1, 23'd7, 32'h00000000, 4'b1010);
        do_xfer(1'b1, 23'd7, 32'h13572468, 4'hF);
        do_xfer(1'b0, 23'd7, '0, 4'h0);
        drain();

        // Stall alignment from a fresh counter with back-to-back reads.
        do_reset();
        for (int i = 0; i < 6; i++) do_xfer(1'b0, 23'(i), '0, 4'h0);
        drain();

        // Write right behind an in-flight read of the same word.
        do_xfer(1'b0, 23'd3, '0, 4'h0);
        do_xfer(1'b1, 23'd3, 32'hAAAA5555, 4'h0);
        do_xfer(1'b0, 23'd3, '0, 4'h0);
        drain();

        // Conflicting request, then sticky error across normal traffic.
        do_bad(23'd4);
        repeat (3) tick();
        do_xfer(1'b0, 23'd2, '0, 4'h0);
        drain();
        do_reset();

        // Reset with reads in flight; memory survives.
        do_xfer(1'b1, 23'd9, 32'hCAFEF00D, 4'h0);
        drain();
        do_xfer(1'b0, 23'd1, '0, 4'h0);
        do_xfer(1'b0, 23'd2, '0, 4'h0);
        do_reset();
        repeat (4) tick();
        do_xfer(1'b0, 23'd9, '0, 4'h0);
        drain();

        // Random traffic with aliased upper address bits.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 19);
            a  = 23'(($urandom << ADDR_BITS) | $urandom_range(0, 15));
            if (op < 8) begin
                do_xfer(1'b1, a, $urandom, 4'($urandom));
            end else if (op < 16) begin
                do_xfer(1'b0, a, '0, 4'h0);
            end else if (op < 19) begin
                s1_chipselect = 1'b0;
                s1_read_n     = 1'($urandom);
                s1_write_n    = 1'($urandom);
                s1_address    = a;
                tick();
                bus_idle();
            end else begin
                do_bad(a);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
